e_bit_scanner: RTL and testbench

- Sits directly downstream of the exponent ROM (e_mem).
- Drives the ROM address and absorbs its 2-cycle registered read latency.
- Serialises the exponent MSB-first (top word first, bit DATA_WIDTH-1 first) to the square-and-multiply ModExp controller over a valid/ready bit stream.
- Prefetches the next word so bits stream at 1 bit/clock with no inter-word bubbles.

---
 rtl/e_bit_scanner_pkg.sv | 17 +
 rtl/e_bit_scanner_lzc.sv | 25 ++
 rtl/e_bit_scanner.sv | 184 ++++++++++++++++++
 tb/tb_e_bit_scanner.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/e_bit_scanner_pkg.sv
// Shared constants and FSM encoding for the exponent bit scanner.
// Defaults match the production exponent ROM; benches override via parameters.
package e_bit_scanner_pkg;

    localparam int E_DATA_WIDTH   = 32;
    localparam int E_ADDR_WIDTH   = 7;
    localparam int E_TOTAL_ADDR   = 128;
    localparam int ROM_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/e_bit_scanner_lzc.sv
// e_lzc: combinational leading-zero counter; an all-zero input returns WIDTH.
module e_lzc
    import e_bit_scanner_pkg::*;
#(
    parameter int WIDTH = E_DATA_WIDTH
) (
    input  logic [WIDTH-1:0]           value,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt_s;

    // Scan upward so the highest set bit determines the final count
    always_comb begin
        cnt_s = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            cnt_s = value[i] ? CW'(WIDTH - 1 - i) : cnt_s;
        end
    end

    assign count = cnt_s;

endmodule

// File: rtl/e_bit_scanner.sv
// e_bit_scanner: reads the exponent ROM top word first and streams it MSB-first.
// Optional SKIP_LEADING_ZEROS_EN drops leading zero bits and flags all-zero exponents.
module e_bit_scanner
    import e_bit_scanner_pkg::*;
#(
    parameter int DATA_WIDTH = E_DATA_WIDTH,
    parameter int ADDR_WIDTH = E_ADDR_WIDTH,
    parameter int TOTAL_ADDR = E_TOTAL_ADDR
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_q,
    output logic                  bit_valid,
    output logic                  bit_out,
    input  logic                  bit_ready,
    output logic                  first_bit,
    output logic                  last_bit,
    output logic                  busy,
    output logic                  done,
    output logic                  zero_exp
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam int LZW = $clog2(DATA_WIDTH + 1);
    localparam int RCW = $clog2(ROM_RD_LATENCY + 1);

    scan_state_e           state_r, state_n;
    logic [ADDR_WIDTH-1:0] e_addr_r;
    logic [DATA_WIDTH-1:0] shift_r, next_word_r;
    logic                  next_valid_r, cur_last_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic                  rd_busy_r;
    logic [RCW-1:0]        rd_cnt_r;
    logic                  bit_valid_r, first_r, last_r;
    logic                  busy_r, done_r, zero_exp_r;

    logic                  xfer_s, rd_hit_s, word_end_s, addr_zero_s, fill_hit_s;
    logic                  word_zero_s, load_fill_s, skip_word_s, load_next_s;
    logic                  finish_s, empty_s, start_s, issue_s;
    logic [LZW-1:0]        lzc_s;

`ifdef SKIP_LEADING_ZEROS_EN
    e_lzc #(.WIDTH(DATA_WIDTH)) u_lzc (
        .value (e_q),
        .count (lzc_s)
    );
    assign word_zero_s = (e_q == {DATA_WIDTH{1'b0}});
`else
    assign lzc_s       = {LZW{1'b0}};
    assign word_zero_s = 1'b0;
`endif

    // A read is outstanding from the edge that issues its address until the
    // edge ROM_RD_LATENCY+1 later, when e_q carries the word.
    assign xfer_s      = bit_valid_r & bit_ready;
    assign rd_hit_s    = rd_busy_r & (rd_cnt_r == RCW'(ROM_RD_LATENCY));
    assign word_end_s  = xfer_s & (bit_cnt_r == {BCW{1'b0}});
    assign addr_zero_s = (e_addr_r == {ADDR_WIDTH{1'b0}});
    assign fill_hit_s  = (state_r == ST_FILL) & rd_hit_s;
    assign load_fill_s = fill_hit_s & ~word_zero_s;
    assign skip_word_s = fill_hit_s & word_zero_s;
    assign load_next_s = (state_r == ST_SHIFT) & word_end_s & ~cur_last_r & next_valid_r;
    assign finish_s    = (state_r == ST_SHIFT) & word_end_s & cur_last_r;
    assign empty_s     = skip_word_s & addr_zero_s;
    assign start_s     = (state_r == ST_IDLE) & start;
    assign issue_s     = start_s | ((load_fill_s | skip_word_s | load_next_s) & ~addr_zero_s);

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_n = ST_FILL;
                else       state_n = ST_IDLE;
            end
            ST_FILL: begin
                if (load_fill_s)  state_n = ST_SHIFT;
                else if (empty_s) state_n = ST_DONE;
                else              state_n = ST_FILL;
            end
            ST_SHIFT: begin
                if (finish_s) state_n = ST_DONE;
                else          state_n = ST_SHIFT;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Address, read tracking, shift datapath and status registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e_addr_r     <= {ADDR_WIDTH{1'b0}};
            shift_r      <= {DATA_WIDTH{1'b0}};
            next_word_r  <= {DATA_WIDTH{1'b0}};
            next_valid_r <= 1'b0;
            cur_last_r   <= 1'b0;
            bit_cnt_r    <= {BCW{1'b0}};
            rd_busy_r    <= 1'b0;
            rd_cnt_r     <= {RCW{1'b0}};
            bit_valid_r  <= 1'b0;
            first_r      <= 1'b0;
            last_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            zero_exp_r   <= 1'b0;
        end else begin
            if (issue_s) begin
                e_addr_r  <= start_s ? ADDR_WIDTH'(TOTAL_ADDR - 1) : e_addr_r - ADDR_WIDTH'(1);
                rd_busy_r <= 1'b1;
                rd_cnt_r  <= {RCW{1'b0}};
            end else if (rd_hit_s) begin
                rd_busy_r <= 1'b0;
                rd_cnt_r  <= {RCW{1'b0}};
            end else if (rd_busy_r) begin
                rd_cnt_r  <= rd_cnt_r + RCW'(1);
            end

            // First word arrives pre-aligned so its top set bit (or MSB) leads
            if (load_fill_s) begin
                shift_r     <= e_q << lzc_s;
                bit_cnt_r   <= BCW'(DATA_WIDTH - 1 - int'(lzc_s));
                cur_last_r  <= addr_zero_s;
                bit_valid_r <= 1'b1;
                first_r     <= 1'b1;
                last_r      <= addr_zero_s & (int'(lzc_s) == DATA_WIDTH - 1);
            end else if (load_next_s) begin
                shift_r     <= next_word_r;
                bit_cnt_r   <= BCW'(DATA_WIDTH - 1);
                cur_last_r  <= addr_zero_s;
                first_r     <= 1'b0;
                last_r      <= 1'b0;
            end else if (finish_s) begin
                shift_r     <= {DATA_WIDTH{1'b0}};
                cur_last_r  <= 1'b0;
                bit_valid_r <= 1'b0;
                first_r     <= 1'b0;
                last_r      <= 1'b0;
            end else if (xfer_s) begin
                shift_r     <= shift_r << 1;
                bit_cnt_r   <= bit_cnt_r - BCW'(1);
                first_r     <= 1'b0;
                last_r      <= cur_last_r & (bit_cnt_r == BCW'(1));
            end

            if (load_next_s) begin
                next_valid_r <= 1'b0;
            end else if ((state_r == ST_SHIFT) && rd_hit_s) begin
                next_word_r  <= e_q;
                next_valid_r <= 1'b1;
            end

            if (start_s) begin
                busy_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                busy_r <= 1'b0;
            end

            done_r     <= finish_s | empty_s;
            zero_exp_r <= empty_s;
        end
    end

    assign e_addr    = e_addr_r;
    assign bit_valid = bit_valid_r;
    assign bit_out   = shift_r[DATA_WIDTH-1];
    assign first_bit = first_r;
    assign last_bit  = last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign zero_exp  = zero_exp_r;

endmodule

// File: tb/tb_e_bit_scanner.sv
// Scoreboard bench for e_bit_scanner with a 2-cycle registered ROM model.
// Expected streams are derived from the memory image as a flat MSB-first bit list.
module tb_e_bit_scanner;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int TA = 4;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    logic          clock = 1'b0;
    logic          resetn, start, bit_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_q;
    logic          bit_valid, bit_out, first_bit, last_bit, busy, done, zero_exp;

    logic [DW-1:0] mem [TA];
    logic [AW-1:0] rom_addr_r;

    exp_t exp_q[$];
    bit   zexp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepted = 0;
    int   dones = 0;
    int   ready_mode = 0;

    e_bit_scanner #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_ADDR(TA)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .e_addr    (e_addr),
        .e_q       (e_q),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .bit_ready (bit_ready),
        .first_bit (first_bit),
        .last_bit  (last_bit),
        .busy      (busy),
        .done      (done),
        .zero_exp  (zero_exp)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rom_addr_r <= e_addr;
        e_q        <= mem[rom_addr_r];
    end

    task automatic push_expect();
        logic stream[$];
        exp_t e;
        for (int w = TA - 1; w >= 0; w--) begin
            for (int b = DW - 1; b >= 0; b--) stream.push_back(mem[w][b]);
        end
`ifdef SKIP_LEADING_ZEROS_EN
        while (stream.size() > 0 && stream[0] == 1'b0) void'(stream.pop_front());
`endif
        for (int i = 0; i < stream.size(); i++) begin
            e.b = stream[i];
            e.f = (i == 0);
            e.l = (i == stream.size() - 1);
            exp_q.push_back(e);
        end
`ifdef SKIP_LEADING_ZEROS_EN
        zexp_q.push_back(stream.size() == 0);
`else
        zexp_q.push_back(1'b0);
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        logic [AW+6:0] got;
        got = {e_addr, bit_valid, bit_out, first_bit, last_bit, busy, done, zero_exp};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%b required all zero", name, got);
        end
    endtask

    initial begin : ready_driver
        int phase = 0;
        bit_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bit_ready = 1'b1;
                1:       bit_ready = (phase == 0 || phase == 3);
                default: bit_ready = 1'($urandom_range(0, 1));
            endcase
            phase = (phase + 1) % 4;
        end
    end

    initial begin : monitor
        exp_t e;
        logic [2:0] stall_val = 3'b000;
        bit stall_pend = 1'b0;
        bit in_scan = 1'b0;
        forever begin
            @(negedge clock);
            if (resetn) begin
                if (stall_pend) begin
                    checks++;
                    if (!bit_valid || {bit_out, first_bit, last_bit} !== stall_val) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b bits=%b required valid=1 bits=%b",
                                 bit_valid, {bit_out, first_bit, last_bit}, stall_val);
                    end
                end
                stall_pend = bit_valid && !bit_ready;
                stall_val  = {bit_out, first_bit, last_bit};
                if (in_scan) begin
                    checks++;
                    if (!bit_valid) begin
                        errors++;
                        $display("FAIL no_bubble: bit_valid=0 required 1 mid-scan");
                    end
                end
                if (bit_valid) in_scan = 1'b1;
                if (bit_valid && bit_ready) begin
                    checks++;
                    accepted++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_bit: got bit/first/last=%b required none",
                                 {bit_out, first_bit, last_bit});
                    end else begin
                        e = exp_q.pop_front();
                        if ({bit_out, first_bit, last_bit} !== e) begin
                            errors++;
                            $display("FAIL stream_bit: got bit/first/last=%b required %b",
                                     {bit_out, first_bit, last_bit}, e);
                        end
                    end
                    if (last_bit) in_scan = 1'b0;
                end
                if (done) begin
                    checks++;
                    dones++;
                    if (zexp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_done: done=1 required no done");
                    end else if (zero_exp !== zexp_q.pop_front()) begin
                        errors++;
                        $display("FAIL zero_exp: got %b required the opposite", zero_exp);
                    end
                end
            end else begin
                stall_pend = 1'b0;
                in_scan    = 1'b0;
            end
        end
    end

    task automatic run_scan(input int mode, input int poke_at, input int reset_at, input bit chk_lat);
        int  d0, a0, n;
        bit  poked, aborted, finished;
        ready_mode = mode;
        d0 = dones;
        a0 = accepted;
        poked = 1'b0;
        aborted = 1'b0;
        finished = 1'b0;
        push_expect();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        if (chk_lat) begin
            n = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                n++;
                if (bit_valid) break;
            end
            checks++;
            if (n != 4) begin
                errors++;
                $display("FAIL fill_latency: first valid at negedge %0d required 4", n);
            end
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            if (poke_at >= 0 && !poked && (accepted - a0) >= poke_at) begin
                poked = 1'b1;
                start = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
            end
            if (reset_at >= 0 && (accepted - a0) >= reset_at) begin
                @(posedge clock);
                #2 resetn = 1'b0;
                #1 check_reset_outputs("async_reset");
                exp_q.delete();
                zexp_q.delete();
                repeat (2) @(negedge clock);
                resetn = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (dones > d0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            if (!finished) begin
                checks++;
                errors++;
                $display("FAIL scan_timeout: no done within budget, %0d bits left", exp_q.size());
            end
            repeat (3) @(negedge clock);
            checks++;
            if ((dones - d0) != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL scan_end: dones=%0d busy=%b left=%0d required 1/0/0",
                         dones - d0, busy, exp_q.size());
            end
        end
    endtask

    task automatic load_mem(input logic [DW-1:0] w3, input logic [DW-1:0] w2,
                            input logic [DW-1:0] w1, input logic [DW-1:0] w0);
        mem[3] = w3;
        mem[2] = w2;
        mem[1] = w1;
        mem[0] = w0;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        load_mem(8'hA5, 8'h00, 8'h00, 8'h01);
        repeat (3) @(posedge clock);
        #1 check_reset_outputs("reset_state");
        @(negedge clock);
        resetn = 1'b1;

        run_scan(0, -1, -1, 1'b1);
        run_scan(1, -1, -1, 1'b0);
        load_mem(8'h00, 8'h00, 8'h13, 8'h80);
        run_scan(0, -1, -1, 1'b0);
        load_mem(8'h00, 8'h00, 8'h00, 8'h00);
        run_scan(2, -1, -1, 1'b0);
        load_mem(8'hA5, 8'h00, 8'h00, 8'h01);
        run_scan(0, -1, 10, 1'b0);
        run_scan(0, -1, -1, 1'b1);
        run_scan(0, 5, -1, 1'b0);
        load_mem(8'h00, 8'h00, 8'h00, 8'h01);
        run_scan(1, -1, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < TA; w++) begin
                mem[w] = ($urandom_range(0, 3) == 0) ? 8'h00 : DW'($urandom);
            end
            run_scan(r % 3, -1, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
